// File: rtl/tdm_demux4.sv
`timescale 1ns/1ps
// tdm_demux4 -- receive side of a 1-bit TDM link.
//
// Locks to the frame-sync marker that accompanies slot 0, collects LANES
// slot bits (one per en strobe) and presents each complete frame as a
// registered parallel word with a one-cycle data_valid pulse. Framing
// violations (early or missing sync) pulse sync_err.
//
// Optional feature macro: TDM_DEMUX_ERRCNT_EN adds err_count, a saturating
// 8-bit count of sync_err pulses.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          slot strobe; data_in/frame_sync sampled only when high
//   data_in     serial slot bit
//   frame_sync  marks the slot-0 bit of each frame
//   data_out    last complete frame, bit i = slot i
//   data_valid  one-cycle pulse when data_out updates
//   select      slot index expected on the next strobe
//   locked      high while frame alignment is held
//   sync_err    one-cycle pulse on a framing violation
//   err_count   (TDM_DEMUX_ERRCNT_EN only) saturating error count
module tdm_demux4 #(
    parameter int LANES = 4,
    localparam int SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             data_in,
    input  logic             frame_sync,
    output logic [LANES-1:0] data_out,
    output logic             data_valid,
    output logic [SEL_W-1:0] select,
    output logic             locked,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic [7:0]       err_count,
`endif
    output logic             sync_err
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(LANES - 1);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [LANES-1:0] shift_q, shift_d;
    logic [LANES-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (en) begin
            if (state_q == HUNT) begin
                if (frame_sync) begin
                    shift_d[0] = data_in;
                    sel_d      = SEL_FIRST;
                    state_d    = LOCKED;
                end
            end else if (frame_sync && (sel_q != '0)) begin
                // Early sync: the partial frame is dropped and the marker
                // is trusted as the start of a new frame.
                err_d      = 1'b1;
                shift_d[0] = data_in;
                sel_d      = SEL_FIRST;
            end else if (!frame_sync && (sel_q == '0)) begin
                // Missing sync: alignment is lost, re-acquire from HUNT.
                err_d   = 1'b1;
                sel_d   = '0;
                state_d = HUNT;
            end else begin
                shift_d[sel_q] = data_in;
                if (sel_q == SEL_LAST) begin
                    // Last slot goes straight into the output word so the
                    // frame appears one clock after its final strobe.
                    dout_d  = shift_d;
                    valid_d = 1'b1;
                    sel_d   = '0;
                end else begin
                    sel_d = sel_q + SEL_FIRST;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            sel_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    // Counts on the same edge that raises sync_err, saturating at 255.
    always_comb begin
        ecnt_d = ecnt_q;
        if (err_d && (ecnt_q != 8'hFF)) begin
            ecnt_d = ecnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign err_count = ecnt_q;
`endif

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign select     = sel_q;
    assign locked     = (state_q == LOCKED);
    assign sync_err   = err_q;

endmodule
